// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, counter width and request validity check.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int CNT_W       = 4;
    localparam int DEF_LATENCY = 4;

    // Conflicting, unaligned or out-of-range requests complete with err.
    function automatic logic req_bad(
        input logic        r,
        input logic        w,
        input logic [15:0] a,
        input int          aw
    );
        logic [15:0] hi;
        hi = a >> (aw + 1);
        return (r & w) | a[0] | (hi != 16'h0000);
    endfunction

endpackage

// File: rtl/mem_array.sv
// 16-bit word store: synchronous write, combinational read,
// synchronous clear on reset.
module mem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls
// the core for LATENCY cycles, then pulses done (and err if bad).
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        addr_q, wdata_q;
    logic               rd_q, wr_q;
    logic               accept;

    logic [15:0]        cur_addr;
    logic               cur_rd, cur_wr, cur_bad, bad_q;
    logic               mem_we, load_rd;
    logic [15:0]        rdata;

    // With LATENCY=1 the read happens on the acceptance edge,
    // so the live inputs stand in for the not-yet-captured copy.
    assign cur_addr = (state_q == IDLE) ? addr : addr_q;
    assign cur_rd   = (state_q == IDLE) ? rd   : rd_q;
    assign cur_wr   = (state_q == IDLE) ? wr   : wr_q;
    assign cur_bad  = req_bad(cur_rd, cur_wr, cur_addr, ADDR_W);
    assign bad_q    = req_bad(rd_q, wr_q, addr_q, ADDR_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd | wr) begin
                    accept = 1'b1;
                    stall  = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                err     = bad_q;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                err     = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mem_we  = (state_q == DONE) && wr_q && !bad_q;
    assign load_rd = (state_d == DONE) && cur_rd && !cur_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            data_out <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= data_in;
                rd_q    <= rd;
                wr_q    <= wr;
            end
            if (load_rd) begin
                data_out <= rdata;
            end
        end
    end

    mem_array #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .waddr(addr_q[ADDR_W:1]),
        .wdata(wdata_q),
        .raddr(cur_addr[ADDR_W:1]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder
// (LATENCY=4 instance plus a LATENCY=1 instance).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] addr, data_in, data_out;
    logic        rd, wr, done, stall, err;

    logic [15:0] addr1, data1_in, data1_out;
    logic        rd1, wr1, done1, stall1, err1;

    int checks = 0;
    int errors = 0;

    // {err, data_out} expected at each done
    logic [16:0] sb  [$];
    logic [16:0] sb1 [$];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .LATENCY(4)) u0 (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .rd(rd), .wr(wr), .data_out(data_out), .done(done),
        .stall(stall), .err(err)
    );

    data_mem_responder #(.ADDR_W(8), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .addr(addr1), .data_in(data1_in),
        .rd(rd1), .wr(wr1), .data_out(data1_out), .done(done1),
        .stall(stall1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request on u0 and wait (bounded) for its done pulse.
    task automatic run_req(input string tag, input logic r,
                           input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] xd,
                           input logic xe);
        int c;
        logic seen;
        logic [16:0] e;
        if (done) @(negedge clk);
        rd = r; wr = w; addr = a; data_in = d;
        sb.push_back({xe, xd});
        #1 chk({tag, "_accept_stall"}, stall, 1);
        seen = 1'b0;
        for (c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (stall && done) chk({tag, "_stall_done"}, 0, 1);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_latency"}, c, 4);
        if (seen) begin
            chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_data"}, data_out, e[15:0]);
                chk({tag, "_err"}, err, e[16]);
            end
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    typedef struct {
        logic        r, w;
        logic [15:0] a, d, xd;
        logic        xe;
    } req_t;

    initial begin
        req_t tbl [5];
        logic [16:0] e;

        rst = 1'b1;
        rd = 0; wr = 0; addr = 0; data_in = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; data1_in = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_data", data_out, 16'h0000);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        chk("rst1_data", data1_out, 16'h0000);

        run_req("t1_rd", 1, 0, 16'h0010, 16'h0000, 16'h0000, 0);
        run_req("t2_wr", 0, 1, 16'h0020, 16'hBEEF, 16'h0000, 0);
        run_req("t2_rd", 1, 0, 16'h0020, 16'h0000, 16'hBEEF, 0);
        run_req("t3_unal", 1, 0, 16'h0021, 16'h0000, 16'hBEEF, 1);
        run_req("t3_rd", 1, 0, 16'h0010, 16'h0000, 16'h0000, 0);
        run_req("t3_rd2", 1, 0, 16'h0020, 16'h0000, 16'hBEEF, 0);
        run_req("t4_both", 1, 1, 16'h0020, 16'h1234, 16'hBEEF, 1);
        run_req("t4_rd", 1, 0, 16'h0020, 16'h0000, 16'hBEEF, 0);

        // write abandoned by reset mid-flight
        @(negedge clk);
        wr = 1; addr = 16'h0040; data_in = 16'hAAAA;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; wr = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t5_no_done", done, 0);
            chk("t5_idle", stall, 0);
            @(negedge clk);
        end
        chk("t5_rst_data", data_out, 16'h0000);
        run_req("t5_rd", 1, 0, 16'h0040, 16'h0000, 16'h0000, 0);
        run_req("t5_rd_beef", 1, 0, 16'h0020, 16'h0000, 16'h0000, 0);

        // LATENCY=1 instance, request held continuously
        tbl[0] = '{1, 0, 16'h0200, 16'h0000, 16'h0000, 1};
        tbl[1] = '{1, 0, 16'h0200, 16'h0000, 16'h0000, 1};
        tbl[2] = '{0, 1, 16'h0010, 16'h5A5A, 16'h0000, 0};
        tbl[3] = '{1, 0, 16'h0010, 16'h0000, 16'h5A5A, 0};
        tbl[4] = '{1, 0, 16'h0012, 16'h0000, 16'h0000, 0};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rd1 = tbl[i].r; wr1 = tbl[i].w;
            addr1 = tbl[i].a; data1_in = tbl[i].d;
            sb1.push_back({tbl[i].xe, tbl[i].xd});
            #1;
            chk("t6_acc_stall", stall1, 1);
            chk("t6_acc_done", done1, 0);
            @(negedge clk);
            chk("t6_done", done1, 1);
            chk("t6_done_stall", stall1, 0);
            if (done1 && sb1.size() > 0) begin
                e = sb1.pop_front();
                chk("t6_data", data1_out, e[15:0]);
                chk("t6_err", err1, e[16]);
            end
            @(negedge clk);
        end
        rd1 = 0; wr1 = 0;
        #1 chk("t6_idle", stall1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
